// File: rtl/fake_rd_interface.sv
`timescale 1ns/1ps
// fake_rd_interface: trigger-started two-line serial frame generator.
// Ports: LOCAL_CLK/RESET (async, high); ENABLE arms the block;
// TRIGGER rising edge starts a frame; ENABLE_XFR marks valid bits on
// SERIAL_OUT0 (word index) and SERIAL_OUT1 (its complement), each word
// sent MSB first and followed by an odd-parity bit.
module fake_rd_interface #(
  parameter int WORD_BITS   = 12,
  parameter int NUM_WORDS   = 16,
  parameter int START_DELAY = 4
) (
  input  logic LOCAL_CLK,
  input  logic RESET,
  input  logic ENABLE,
  input  logic TRIGGER,
  output logic ENABLE_XFR,
  output logic SERIAL_OUT0,
  output logic SERIAL_OUT1
);

  localparam int BW = $clog2(WORD_BITS + 1);
  localparam logic [7:0]    LAST_DLY  = 8'(START_DELAY - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_BITS);
  localparam logic [11:0]   LAST_WORD = 12'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, DELAY, XFER} state_t;

  state_t        state_q, state_n;
  logic [7:0]    dly_q, dly_n;
  logic [BW-1:0] bit_q, bit_n;
  logic [11:0]   word_q, word_n;

  logic sync1, sync2, prev;
  logic [1:0] vld;
  logic armed;
  logic edge_det;

  // armed only sets once a genuine low level has passed the
  // synchronizer, so a trigger already high at reset release
  // cannot look like a fresh rising edge.
  always_ff @(posedge LOCAL_CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      vld   <= 2'b00;
      armed <= 1'b0;
    end else begin
      sync1 <= TRIGGER;
      sync2 <= sync1;
      prev  <= sync2;
      vld   <= {vld[0], 1'b1};
      if (vld[1] && !sync2)
        armed <= 1'b1;
    end
  end

  assign edge_det = sync2 & ~prev & armed;

  always_comb begin
    state_n = state_q;
    dly_n   = dly_q;
    bit_n   = bit_q;
    word_n  = word_q;
    unique case (state_q)
      IDLE: begin
        if (ENABLE && edge_det) begin
          state_n = DELAY;
          dly_n   = '0;
        end
      end
      DELAY: begin
        if (!ENABLE) begin
          state_n = IDLE;
          dly_n   = '0;
        end else if (dly_q == LAST_DLY) begin
          state_n = XFER;
          dly_n   = '0;
          bit_n   = '0;
          word_n  = '0;
        end else begin
          dly_n = dly_q + 8'd1;
        end
      end
      XFER: begin
        if (!ENABLE) begin
          state_n = IDLE;
          bit_n   = '0;
          word_n  = '0;
        end else if (bit_q == LAST_BIT) begin
          bit_n = '0;
          if (word_q == LAST_WORD) begin
            state_n = IDLE;
            word_n  = '0;
          end else begin
            word_n = word_q + 12'd1;
          end
        end else begin
          bit_n = bit_q + BW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        dly_n   = '0;
        bit_n   = '0;
        word_n  = '0;
      end
    endcase
  end

  // Outputs are computed from the next-state counters and registered,
  // so they change on the same edge as the state they describe.
  logic [WORD_BITS-1:0] data0, data1, sh0, sh1;
  logic xfr_n, s0_n, s1_n;

  always_comb begin
    data0 = WORD_BITS'(word_n);
    data1 = ~data0;
    sh0   = data0 << bit_n;
    sh1   = data1 << bit_n;
    xfr_n = (state_n == XFER);
    s0_n  = 1'b0;
    s1_n  = 1'b0;
    if (xfr_n) begin
      if (bit_n == LAST_BIT) begin
        s0_n = ~^data0;
        s1_n = ~^data1;
      end else begin
        s0_n = sh0[WORD_BITS-1];
        s1_n = sh1[WORD_BITS-1];
      end
    end
  end

  always_ff @(posedge LOCAL_CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      dly_q       <= '0;
      bit_q       <= '0;
      word_q      <= '0;
      ENABLE_XFR  <= 1'b0;
      SERIAL_OUT0 <= 1'b0;
      SERIAL_OUT1 <= 1'b0;
    end else begin
      state_q     <= state_n;
      dly_q       <= dly_n;
      bit_q       <= bit_n;
      word_q      <= word_n;
      ENABLE_XFR  <= xfr_n;
      SERIAL_OUT0 <= s0_n;
      SERIAL_OUT1 <= s1_n;
    end
  end

endmodule

// File: tb/tb_fake_rd_interface.sv
`timescale 1ns/1ps
// tb_fake_rd_interface: randomized frame bench with a word-level
// reference model of the serial frame content and timing.
module tb_fake_rd_interface;

  localparam int WB   = 12;
  localparam int NW   = 16;
  localparam int SD   = 4;
  localparam int L    = NW * (WB + 1);
  localparam int FMAX = 256;

  logic clk = 1'b0;
  logic rst, en, trig;
  logic ex, s0, s1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nframes = 0;
  int idle_nz = 0;

  bit in_frame = 1'b0;
  int cs = 0, cl = 0, fs = -1, fl = -1;
  logic cb0[FMAX], cb1[FMAX], fb0[FMAX], fb1[FMAX];

  fake_rd_interface #(
    .WORD_BITS(WB),
    .NUM_WORDS(NW),
    .START_DELAY(SD)
  ) dut (
    .LOCAL_CLK(clk),
    .RESET(rst),
    .ENABLE(en),
    .TRIGGER(trig),
    .ENABLE_XFR(ex),
    .SERIAL_OUT0(s0),
    .SERIAL_OUT1(s1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame recorder: captures each ENABLE_XFR burst.
  always @(negedge clk) begin
    if (ex === 1'b1) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        cs = cyc;
        cl = 0;
      end
      if (cl < FMAX) begin
        cb0[cl] = s0;
        cb1[cl] = s1;
      end
      cl++;
    end else begin
      if (in_frame) begin
        in_frame = 1'b0;
        fs = cs;
        fl = cl;
        fb0 = cb0;
        fb1 = cb1;
        nframes++;
      end
      if (s0 !== 1'b0 || s1 !== 1'b0) idle_nz++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic exp_bit(input int line, input int p);
    int w, b, d;
    w = p / (WB + 1);
    b = p % (WB + 1);
    d = w % (1 << WB);
    if (line == 1) d = (1 << WB) - 1 - d;
    if (b < WB) return 1'((d >> (WB - 1 - b)) & 1);
    return ($countones(d) % 2) == 0;
  endfunction

  function automatic int frame_errs(input int n);
    int e = 0;
    for (int i = 0; i < n && i < FMAX; i++) begin
      if (fb0[i] !== exp_bit(0, i)) e++;
      if (fb1[i] !== exp_bit(1, i)) e++;
    end
    return e;
  endfunction

  task automatic pulse(input int hi, output int e0);
    @(negedge clk);
    #2 trig = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    repeat (hi - 1) @(posedge clk);
    #3 trig = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget,
                             output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (nframes >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_cyc(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en = 1'b0;
    trig = 1'b0;
    #3;
    total++;
    if (ex !== 1'b0) begin
      bad++;
      $display("FAIL rst_enable_xfr got=%b want=0", ex);
    end
    total++;
    if (s0 !== 1'b0) begin
      bad++;
      $display("FAIL rst_serial0 got=%b want=0", s0);
    end
    total++;
    if (s1 !== 1'b0) begin
      bad++;
      $display("FAIL rst_serial1 got=%b want=0", s1);
    end
    #14 rst = 1'b0;
    #3 en = 1'b1;
  endtask

  task automatic test_basic_frame;
    int e0, n0, base;
    bit ok;
    logic [WB-1:0] o0, o1, x0, x1;
    logic p0, p1, q0, q1;
    logic [WB:0] w3, w3x;
    n0 = nframes;
    repeat (5) @(negedge clk);
    pulse(6, e0);
    wait_frames(n0 + 1, 400, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_timeout got=none want=frame");
    end
    total++;
    if (fs !== e0 + 2 + SD) begin
      bad++;
      $display("FAIL basic_start got=%0d want=%0d", fs, e0 + 2 + SD);
    end
    total++;
    if (fl !== L) begin
      bad++;
      $display("FAIL basic_len got=%0d want=%0d", fl, L);
    end
    for (int w = 0; w < NW; w++) begin
      base = w * (WB + 1);
      for (int b = 0; b < WB; b++) begin
        o0[WB-1-b] = fb0[base + b];
        o1[WB-1-b] = fb1[base + b];
      end
      p0 = fb0[base + WB];
      p1 = fb1[base + WB];
      x0 = WB'(w);
      x1 = ~x0;
      q0 = ($countones(x0) % 2) == 0;
      q1 = ($countones(x1) % 2) == 0;
      total++;
      if ({o0, p0} !== {x0, q0}) begin
        bad++;
        $display("FAIL word0_%0d got=%h/%b want=%h/%b",
                 w, o0, p0, x0, q0);
      end
      total++;
      if ({o1, p1} !== {x1, q1}) begin
        bad++;
        $display("FAIL word1_%0d got=%h/%b want=%h/%b",
                 w, o1, p1, x1, q1);
      end
    end
    w3x = 13'b0000000000111;
    for (int b = 0; b <= WB; b++)
      w3[WB-b] = fb0[3 * (WB + 1) + b];
    total++;
    if (w3 !== w3x) begin
      bad++;
      $display("FAIL word3_line0 got=%b want=%b", w3, w3x);
    end
  endtask

  task automatic test_random_frames;
    int e0, n0, gap, wid, er;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      gap = $urandom_range(3, 20);
      wid = $urandom_range(1, 10);
      n0 = nframes;
      repeat (gap) @(negedge clk);
      pulse(wid, e0);
      wait_frames(n0 + 1, 400, ok);
      total++;
      if (!ok || fs !== e0 + 2 + SD) begin
        bad++;
        $display("FAIL rand_start_%0d got=%0d want=%0d",
                 k, fs, e0 + 2 + SD);
      end
      total++;
      if (fl !== L) begin
        bad++;
        $display("FAIL rand_len_%0d got=%0d want=%0d", k, fl, L);
      end
      er = frame_errs(L);
      total++;
      if (er !== 0) begin
        bad++;
        $display("FAIL rand_data_%0d got=%0d bad bits want=0", k, er);
      end
    end
  endtask

  task automatic test_ignore_retrigger;
    int e0, e1, n0, s, k, er;
    bit ok;
    n0 = nframes;
    repeat (4) @(negedge clk);
    pulse(3, e0);
    s = e0 + 2 + SD;
    k = $urandom_range(10, 150);
    wait_cyc(s + k);
    pulse(2, e1);
    wait_frames(n0 + 1, 400, ok);
    er = frame_errs(L);
    total++;
    if (!ok || fs !== s || fl !== L) begin
      bad++;
      $display("FAIL retrig_frame got=%0d/%0d want=%0d/%0d",
               fs, fl, s, L);
    end
    total++;
    if (er !== 0) begin
      bad++;
      $display("FAIL retrig_data got=%0d bad bits want=0", er);
    end
    repeat (40) @(negedge clk);
    #1;
    total++;
    if (nframes !== n0 + 1) begin
      bad++;
      $display("FAIL retrig_count got=%0d want=%0d",
               nframes - n0, 1);
    end
  endtask

  task automatic test_back_to_back;
    int e0, e1, n0, s, er;
    bit ok;
    n0 = nframes;
    repeat (4) @(negedge clk);
    pulse(2, e0);
    s = e0 + 2 + SD;
    wait_cyc(s + L - 2);
    #2 trig = 1'b1;
    @(posedge clk);
    #1 e1 = cyc;
    @(posedge clk);
    #3 trig = 1'b0;
    wait_frames(n0 + 2, 500, ok);
    er = frame_errs(L);
    total++;
    if (!ok || fs !== s + L + SD + 1) begin
      bad++;
      $display("FAIL b2b_start got=%0d want=%0d",
               fs, s + L + SD + 1);
    end
    total++;
    if (fl !== L || er !== 0) begin
      bad++;
      $display("FAIL b2b_frame got=%0d/%0d want=%0d/0", fl, er, L);
    end
  endtask

  task automatic test_held_trigger;
    int e0, n0;
    n0 = nframes;
    repeat (4) @(negedge clk);
    pulse(300, e0);
    @(negedge clk);
    #1;
    total++;
    if (nframes !== n0 + 1 || fs !== e0 + 2 + SD || fl !== L) begin
      bad++;
      $display("FAIL held_frame got=%0d/%0d/%0d want=1/%0d/%0d",
               nframes - n0, fs, fl, e0 + 2 + SD, L);
    end
    repeat (30) @(negedge clk);
    #1;
    total++;
    if (nframes !== n0 + 1) begin
      bad++;
      $display("FAIL held_retrigger got=%0d want=1", nframes - n0);
    end
  endtask

  task automatic test_abort;
    int e0, e1, n0, s, er;
    bit ok;
    n0 = nframes;
    repeat (4) @(negedge clk);
    pulse(2, e0);
    s = e0 + 2 + SD;
    wait_cyc(s + 50);
    #2 en = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({ex, s0, s1} !== 3'b000) begin
      bad++;
      $display("FAIL abort_outputs got=%b want=000", {ex, s0, s1});
    end
    wait_frames(n0 + 1, 10, ok);
    er = frame_errs(51);
    total++;
    if (!ok || fl !== 51 || er !== 0) begin
      bad++;
      $display("FAIL abort_partial got=%0d/%0d want=51/0", fl, er);
    end
    repeat (3) @(negedge clk);
    pulse(2, e1);
    repeat (250) @(negedge clk);
    #1;
    total++;
    if (nframes !== n0 + 1) begin
      bad++;
      $display("FAIL abort_disabled_trig got=%0d want=1",
               nframes - n0);
    end
    en = 1'b1;
    repeat (3) @(negedge clk);
    pulse(2, e1);
    wait_frames(n0 + 2, 400, ok);
    er = frame_errs(L);
    total++;
    if (!ok || fs !== e1 + 2 + SD || fl !== L || er !== 0) begin
      bad++;
      $display("FAIL abort_rearm got=%0d/%0d/%0d want=%0d/%0d/0",
               fs, fl, er, e1 + 2 + SD, L);
    end
    n0 = nframes;
    pulse(1, e0);
    wait_cyc(e0 + 3);
    #2 en = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    total++;
    if (nframes !== n0 || ex !== 1'b0) begin
      bad++;
      $display("FAIL abort_delay got=%0d/%b want=0/0",
               nframes - n0, ex);
    end
    en = 1'b1;
  endtask

  task automatic test_reset_midframe;
    int e0, e1, n0, s, er;
    bit ok;
    n0 = nframes;
    repeat (4) @(negedge clk);
    pulse(2, e0);
    s = e0 + 2 + SD;
    wait_cyc(s + 100);
    #1 trig = 1'b1;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({ex, s0, s1} !== 3'b000) begin
      bad++;
      $display("FAIL rst_async got=%b want=000", {ex, s0, s1});
    end
    #13 rst = 1'b0;
    wait_frames(n0 + 1, 5, ok);
    er = frame_errs(101);
    total++;
    if (!ok || fl !== 101 || er !== 0) begin
      bad++;
      $display("FAIL rst_partial got=%0d/%0d want=101/0", fl, er);
    end
    repeat (300) @(negedge clk);
    #1;
    total++;
    if (nframes !== n0 + 1) begin
      bad++;
      $display("FAIL rst_held_trig got=%0d want=1", nframes - n0);
    end
    trig = 1'b0;
    repeat (4) @(negedge clk);
    pulse(2, e1);
    wait_frames(n0 + 2, 400, ok);
    er = frame_errs(L);
    total++;
    if (!ok || fs !== e1 + 2 + SD || fl !== L || er !== 0) begin
      bad++;
      $display("FAIL rst_rearm got=%0d/%0d/%0d want=%0d/%0d/0",
               fs, fl, er, e1 + 2 + SD, L);
    end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_random_frames;
    test_ignore_retrigger;
    test_back_to_back;
    test_held_trigger;
    test_abort;
    test_reset_midframe;
    total++;
    if (idle_nz !== 0) begin
      bad++;
      $display("FAIL idle_serial got=%0d nonzero samples want=0",
               idle_nz);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fake_rd_interface.md
FAKE_RD_INTERFACE -- requirements
Module: fake_rd_interface

Interface
- REQ-001: Parameter WORD_BITS, default 12: data bits per serial word.
- REQ-002: Parameter NUM_WORDS, default 16, legal 1..4096: words per transfer frame, per line.
- REQ-003: Parameter START_DELAY, default 4, legal 1..255: idle cycles between trigger detection and frame start.
- REQ-004: Single clock domain, LOCAL_CLK. RESET is asynchronous and active-high.
- REQ-005: LOCAL_CLK  in  1  system clock; all state updates on its rising edge.
- REQ-006: RESET  in  1  asynchronous active-high reset.
- REQ-007: ENABLE  in  1  synchronous, level: 1 = block armed; 0 = idle/abort.
- REQ-008: TRIGGER  in  1  asynchronous trigger; only a rising edge is significant.
- REQ-009: ENABLE_XFR  out  1  registered; high exactly while frame bits are valid on SERIAL_OUT0/1.
- REQ-010: SERIAL_OUT0  out  1  registered serial data, line 0.
- REQ-011: SERIAL_OUT1  out  1  registered serial data, line 1.

Function
- REQ-012: TRIGGER passes through a 2-flop synchronizer. A rising edge is detected when the synchronized value is 1 and its previous registered value is 0.
- REQ-013: FSM states are IDLE, DELAY and XFER.
  - IDLE -> DELAY on a detected edge while ENABLE=1.
  - DELAY lasts START_DELAY cycles, then -> XFER.
  - XFER lasts L = NUM_WORDS*(WORD_BITS+1) cycles, then -> IDLE.
- REQ-014: Timing reference: E0 is the first LOCAL_CLK edge sampling TRIGGER=1 with ENABLE=1. ENABLE_XFR and frame bit 0 become valid after edge E0+2+START_DELAY. ENABLE_XFR stays high for exactly L consecutive cycles.
- REQ-015: Frame structure: word w (w = 0..NUM_WORDS-1) occupies WORD_BITS+1 consecutive cycles.
  - Data bits are sent MSB first.
  - The last cycle of each word is an odd-parity bit: data bits plus parity contain an odd number of ones.
- REQ-016: SERIAL_OUT0 word w data = w mod 2^WORD_BITS.
- REQ-017: SERIAL_OUT1 word w data = bitwise complement of the SERIAL_OUT0 word.
- REQ-018: Whenever ENABLE_XFR=0, both SERIAL_OUT0 and SERIAL_OUT1 are 0.
- REQ-019: Trigger edges detected in DELAY or XFER are ignored; they are not queued and do not extend the frame.
- REQ-020: The TRIGGER level does not matter after detection. A trigger held high for the entire frame does not retrigger; a new frame requires a new 0->1 transition.
- REQ-021: ENABLE=0 sampled in DELAY or XFER aborts.
  - On the next edge: FSM to IDLE, ENABLE_XFR=0, serial outputs 0.
  - Word/bit counters clear.
  - A later frame starts again from word 0.
- REQ-022: Trigger edges detected while ENABLE=0 are discarded.
- REQ-023: Back-to-back frames: an edge detected in the cycle immediately after XFER ends (FSM in IDLE) starts a new frame. The minimum gap between frames is START_DELAY+1 cycles of ENABLE_XFR=0.
- REQ-024: Counters are sized for the maximum parameter values. There is no overflow or wrap inside a frame.

Reset
- REQ-025: While RESET=1, independent of the clock:
  - FSM = IDLE; all counters cleared.
  - Synchronizer and edge-detect flops cleared.
  - ENABLE_XFR = 0, SERIAL_OUT0 = 0, SERIAL_OUT1 = 0.
- REQ-026: RESET asserted mid-frame terminates the frame immediately; no partial word completes.
- REQ-027: After RESET release, a TRIGGER already high produces no frame until it goes low and high again.

Verification
- REQ-028: Basic frame (defaults, 10 ns clock): ENABLE=1 at 20 ns, TRIGGER 1 from 70 to 130 ns.
  - ENABLE_XFR rises 6 cycles after E0 and stays high 208 cycles.
  - Line 0 word 0 = 000000000000, parity 1.
  - Line 1 word 0 = 111111111111, parity 1.
- REQ-029: Data check: decode all 16 words.
  - Line 0 = 0..15; line 1 = complements 0xFFF..0xFF0.
  - Every 13-bit group has odd parity.
  - Word 3 on line 0 = 000000000011 followed by parity 1.
- REQ-030: Ignore and re-arm:
  - Second TRIGGER pulse during XFER -> frame length unchanged at 208 cycles, no second frame.
  - Pulse after the frame ends -> new frame starting at word 0.
- REQ-031: Abort: drop ENABLE at frame cycle 50.
  - ENABLE_XFR and both serial outputs are 0 from the next edge onward.
  - A trigger pulse while ENABLE=0 -> no frame.
  - Re-enable plus a trigger -> full frame from word 0.
- REQ-032: Reset mid-frame: pulse RESET asynchronously (not clock-aligned) at frame cycle 100.
  - Outputs go to 0 without waiting for a clock edge.
  - TRIGGER held high through RESET release -> no frame.
  - Toggle TRIGGER low then high -> normal frame.
